// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote per bit.
// Received bytes land in a one-entry valid/ready holding register; framing and
// overrun conditions are reported as single-cycle pulses.
module uart_rx_os #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int DIV   = clk_freq / (baud_rate * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Majority of three samples; tolerates one corrupted sample per bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       sub_r;
  logic             samp7_r;
  logic             samp8_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic             os_tick_s;
  logic             tick9_s;
  logic             tick15_s;
  logic             vote_s;
  logic             deliver_s;
  logic             frame_err_s;

  assign os_tick_s = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST);
  assign tick9_s   = os_tick_s && (sub_r == 4'd9);
  assign tick15_s  = os_tick_s && (sub_r == 4'd15);
  assign vote_s    = maj3(samp7_r, samp8_r, rx_sync_r);

  // Two-flop synchronizer for the asynchronous rx pin (idles high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Oversample divider and sub-bit counter; both held at zero while idle so the
  // sampling phase is anchored to the detected start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= '0;
      sub_r     <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r <= '0;
      sub_r     <= 4'd0;
    end else if (os_tick_s) begin
      div_cnt_r <= '0;
      sub_r     <= sub_r + 4'd1;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live rx_sync_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp7_r <= 1'b1;
      samp8_r <= 1'b1;
    end else if (os_tick_s && (sub_r == 4'd7)) begin
      samp7_r <= rx_sync_r;
    end else if (os_tick_s && (sub_r == 4'd8)) begin
      samp8_r <= rx_sync_r;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic plus single-cycle delivery / framing-error strobes.
  always_comb begin
    state_nxt_s = state_r;
    deliver_s   = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick9_s && vote_s) begin
          state_nxt_s = ST_IDLE;
        end else if (tick15_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick15_s && (idx_r == 3'd7)) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        // Return to idle mid stop bit so the next start edge is caught early.
        if (tick9_s && vote_s) begin
          state_nxt_s = ST_IDLE;
          deliver_s   = 1'b1;
        end else if (tick9_s) begin
          state_nxt_s = ST_BREAK;
          frame_err_s = 1'b1;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Data bit shift register, LSB first, indexed by the bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else if (state_r == ST_START) begin
      idx_r <= 3'd0;
    end else if (state_r == ST_DATA) begin
      if (tick9_s) begin
        shift_r[idx_r] <= vote_s;
      end
      if (tick15_s && (idx_r != 3'd7)) begin
        idx_r <= idx_r + 3'd1;
      end
    end
  end

  // Holding register, busy flag and error pulses, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_out <= 8'h00;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_busy     <= (state_nxt_s != ST_IDLE);
      framing_err <= frame_err_s;
      overrun     <= deliver_s && rx_valid && !rx_ready;
      if (deliver_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data_out <= shift_r;
          rx_valid    <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os, run with a small divider (8 clk per
// oversample tick, 128 clk per bit) to keep frames short.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1280;
  localparam int BAUD     = 10;
  localparam int DIV      = 8;
  localparam int BIT      = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun;

  uart_rx_os #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
    .rx_data_out(rx_data_out), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         rd_idx = 0;
  int         fe_cnt = 0;
  int         ovr_cnt = 0;
  int         both_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         spike_bit;
    int         exp_bytes;
    int         exp_fe;
    logic       exp_busy_end;
  } vec_t;
  vec_t vecs[7];

  // Record accepted bytes and error pulses on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data_out);
      if (framing_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (framing_err && overrun) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check_sb(input string tag);
    while (rd_idx < got_q.size()) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_extra actual=%0d expected=none", tag, got_q[rd_idx]);
      end else begin
        chk({tag, "_data"}, int'(got_q[rd_idx]), int'(exp_q.pop_front()));
      end
      rd_idx++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Drive one frame; spike_bit selects a frame bit (0=start) whose value is
  // inverted for DIV clocks around its middle sample.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit,
                            output logic busy_mid, output logic busy_end);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    busy_mid = 1'b0;
    busy_end = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT; c++) begin
        step();
        if (b == spike_bit && c >= 68 && c < 68 + DIV) rx = ~bits[b];
        else rx = bits[b];
        if (b == 5 && c == 64) busy_mid = rx_busy;
        if (b == 9 && c == BIT - 1) busy_end = rx_busy;
      end
    end
  endtask

  initial begin
    logic bm, be;
    int   fe0, ovr0, n0;
    logic [9:0] pb;

    vecs[0] = '{8'h55, 1'b1, -1, 1, 0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, -1, 1, 0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, -1, 1, 0, 1'b0};
    vecs[3] = '{8'h0F, 1'b1,  3, 1, 0, 1'b0};
    vecs[4] = '{8'hA5, 1'b1,  6, 1, 0, 1'b0};
    vecs[5] = '{8'hA3, 1'b0, -1, 0, 1, 1'b1};
    vecs[6] = '{8'h80, 1'b1, -1, 1, 0, 1'b0};

    // Reset state
    idle(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_data", rx_data_out, 0);
    chk("rst_fe", framing_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b1;
    idle(4);

    // Table-driven frames with the consumer always ready
    for (int i = 0; i < 7; i++) begin
      rx_ready = 1'b1;
      fe0 = fe_cnt; ovr0 = ovr_cnt; n0 = got_q.size();
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike_bit, bm, be);
      chk("vec_busy_mid", bm, 1);
      chk("vec_busy_end", be, vecs[i].exp_busy_end);
      if (!vecs[i].stop) begin
        idle(2 * BIT);
        chk("brk_busy", rx_busy, 1);
        chk("brk_valid", rx_valid, 0);
        rx = 1'b1;
        idle(8);
        chk("brk_release_busy", rx_busy, 0);
      end
      idle(16);
      chk("vec_bytes", got_q.size() - n0, vecs[i].exp_bytes);
      chk("vec_fe", fe_cnt - fe0, vecs[i].exp_fe);
      chk("vec_ovr", ovr_cnt - ovr0, 0);
      check_sb("vec_sb");
    end

    // False start: short low pulse must abort in START
    rx_ready = 1'b1;
    fe0 = fe_cnt; n0 = got_q.size();
    step(); rx = 1'b0;
    idle(20);
    chk("fs_busy_hi", rx_busy, 1);
    idle(30);
    rx = 1'b1;
    idle(BIT);
    chk("fs_busy_lo", rx_busy, 0);
    chk("fs_valid", rx_valid, 0);
    chk("fs_bytes", got_q.size() - n0, 0);
    chk("fs_fe", fe_cnt - fe0, 0);

    // Overrun: two back-to-back frames with the consumer stalled
    rx_ready = 1'b0;
    fe0 = fe_cnt; ovr0 = ovr_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1, bm, be);
    chk("ovr_first_valid", rx_valid, 1);
    send_frame(8'h34, 1'b1, -1, bm, be);
    idle(16);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data_out, 8'h12);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    chk("ovr_fe", fe_cnt - fe0, 0);
    step(); rx_ready = 1'b1;
    step(); rx_ready = 1'b0;
    chk("ovr_cleared", rx_valid, 0);
    check_sb("ovr_sb");

    // Reset mid-frame with a byte still held, then recovery
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, bm, be);
    idle(16);
    chk("mr_pre_valid", rx_valid, 1);
    pb = {1'b1, 8'hC6, 1'b0};
    for (int k = 0; k < 5 * BIT + 40; k++) begin
      step();
      rx = pb[k / BIT];
    end
    chk("mr_pre_busy", rx_busy, 1);
    rst = 1'b0;
    #1;
    chk("mr_valid", rx_valid, 0);
    chk("mr_busy", rx_busy, 0);
    chk("mr_data", rx_data_out, 0);
    chk("mr_fe", framing_err, 0);
    chk("mr_ovr", overrun, 0);
    exp_q.delete();
    rd_idx = got_q.size();
    rx = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(5);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, -1, bm, be);
    idle(16);
    chk("mr_post_valid", rx_valid, 1);
    chk("mr_post_data", rx_data_out, 8'hFF);
    step(); rx_ready = 1'b1;
    step(); rx_ready = 1'b0;
    check_sb("mr_sb");

    chk("err_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
